rtu_rob_multi: RTL and testbench

RTU_ROB_MULTI -- requirements
Module: rtu_rob_multi

---
 rtl/rtu_rob_multi.sv | 191 +++++++++++++++++++
 tb/tb_rtu_rob_multi.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtu_rob_multi.sv
`default_nettype none
// ============================================================================
// Module      : rtu_rob_multi
// Description : Reorder buffer with multi-port completion, in-order retire of
//               up to RETIRE_W entries per cycle and jump-triggered flush.
//               Optional retire counter enabled by RTU_ROB_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rtu_rob_multi #(
    parameter int DEPTH    = 16,
    parameter int IID_W    = 4,
    parameter int NUM_CPL  = 5,
    parameter int RETIRE_W = 2
) (
    input  logic                      clk,
    input  logic                      rst_clk,
    input  logic                      create_vld,
    output logic                      create_rdy,
    output logic [IID_W-1:0]          create_iid,
    input  logic [63:0]               create_pc,
    input  logic                      create_pdst_vld,
    input  logic [5:0]                create_pdst,
    input  logic [NUM_CPL-1:0]        cpl_vld,
    input  logic [NUM_CPL*IID_W-1:0]  cpl_iid,
    input  logic                      pcjump_vld,
    input  logic [IID_W-1:0]          pcjump_iid,
    output logic [RETIRE_W-1:0]       retire_vld,
    output logic [RETIRE_W*IID_W-1:0] retire_iid,
    output logic [RETIRE_W*64-1:0]    retire_pc,
    output logic [RETIRE_W-1:0]       retire_pdst_vld,
    output logic [RETIRE_W*6-1:0]     retire_pdst,
    output logic                      rtu_global_flush,
    output logic [IID_W:0]            entry_cnt,
    output logic [31:0]               perf_retire_cnt
);

    localparam logic [IID_W:0] c_ptr_one = (IID_W+1)'(1);

    logic [IID_W:0]    r_head;
    logic [IID_W:0]    r_tail;
    logic [DEPTH-1:0]  r_vld;
    logic [DEPTH-1:0]  r_cmplt;
    logic [DEPTH-1:0]  r_jump;
    logic [DEPTH-1:0]  r_pdst_vld;
    logic [63:0]       r_pc   [DEPTH];
    logic [5:0]        r_pdst [DEPTH];
    logic              r_flush;

    logic              w_full;
    logic              w_create_fire;
    logic [IID_W-1:0]  w_slot_idx [RETIRE_W];
    logic [RETIRE_W-1:0] w_ret_vld;
    logic              w_ret_jump;
    logic [IID_W:0]    w_ret_cnt;
    logic [DEPTH-1:0]  w_cpl_hit;
    logic [DEPTH-1:0]  w_jmp_hit;
    logic [DEPTH-1:0]  w_ret_clr;

    // Same index with differing wrap bits means every entry is occupied.
    assign w_full = (r_head[IID_W-1:0] == r_tail[IID_W-1:0]) &&
                    (r_head[IID_W] != r_tail[IID_W]);

    assign create_rdy       = !w_full && !r_flush;
    assign create_iid       = r_tail[IID_W-1:0];
    assign w_create_fire    = create_vld && create_rdy;
    assign rtu_global_flush = r_flush;
    assign entry_cnt        = r_tail - r_head;
    assign retire_vld       = w_ret_vld;

    generate
        for (genvar k = 0; k < RETIRE_W; k++) begin : g_slot
            assign w_slot_idx[k] = r_head[IID_W-1:0] + IID_W'(k);
            assign retire_iid[k*IID_W +: IID_W] = w_slot_idx[k];
            assign retire_pc[k*64 +: 64]        = r_pc[w_slot_idx[k]];
            assign retire_pdst_vld[k]           = r_pdst_vld[w_slot_idx[k]];
            assign retire_pdst[k*6 +: 6]        = r_pdst[w_slot_idx[k]];
        end
    endgenerate

    // Retire chain: each slot needs all older slots retiring and no older jump.
    always_comb begin
        logic l_go;
        w_ret_vld  = '0;
        w_ret_jump = 1'b0;
        w_ret_cnt  = '0;
        l_go       = !r_flush;
        for (int k = 0; k < RETIRE_W; k++) begin
            if (l_go && r_vld[w_slot_idx[k]] && r_cmplt[w_slot_idx[k]]) begin
                w_ret_vld[k] = 1'b1;
                w_ret_cnt    = w_ret_cnt + c_ptr_one;
                if (r_jump[w_slot_idx[k]]) begin
                    w_ret_jump = 1'b1;
                    l_go       = 1'b0;
                end
            end else begin
                l_go = 1'b0;
            end
        end
    end

    always_comb begin
        w_cpl_hit = '0;
        w_jmp_hit = '0;
        w_ret_clr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int p = 0; p < NUM_CPL; p++) begin
                if (cpl_vld[p] && (cpl_iid[p*IID_W +: IID_W] == IID_W'(i))) begin
                    w_cpl_hit[i] = 1'b1;
                end
            end
            if (pcjump_vld && (pcjump_iid == IID_W'(i))) begin
                w_jmp_hit[i] = 1'b1;
            end
        end
        for (int k = 0; k < RETIRE_W; k++) begin
            if (w_ret_vld[k]) begin
                w_ret_clr[w_slot_idx[k]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_clk) begin
        if (rst_clk) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_vld   <= '0;
            r_cmplt <= '0;
            r_jump  <= '0;
            r_flush <= 1'b0;
        end else if (r_flush) begin
            // Flush cycle: drop everything and ignore all incoming traffic.
            r_head  <= '0;
            r_tail  <= '0;
            r_vld   <= '0;
            r_cmplt <= '0;
            r_jump  <= '0;
            r_flush <= 1'b0;
        end else begin
            r_head  <= r_head + w_ret_cnt;
            r_flush <= w_ret_jump;
            if (w_create_fire) begin
                r_tail <= r_tail + c_ptr_one;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_ret_clr[i]) begin
                    r_vld[i]   <= 1'b0;
                    r_cmplt[i] <= 1'b0;
                    r_jump[i]  <= 1'b0;
                end else if (w_create_fire && (r_tail[IID_W-1:0] == IID_W'(i))) begin
                    r_vld[i]   <= 1'b1;
                    r_cmplt[i] <= 1'b0;
                    r_jump[i]  <= 1'b0;
                end else if (r_vld[i]) begin
                    if (w_cpl_hit[i]) begin
                        r_cmplt[i] <= 1'b1;
                    end
                    if (w_jmp_hit[i]) begin
                        r_jump[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Payload storage needs no reset; validity lives in r_vld.
    always_ff @(posedge clk) begin
        if (w_create_fire) begin
            r_pc[r_tail[IID_W-1:0]]       <= create_pc;
            r_pdst_vld[r_tail[IID_W-1:0]] <= create_pdst_vld;
            r_pdst[r_tail[IID_W-1:0]]     <= create_pdst;
        end
    end

`ifdef RTU_ROB_PERF_CNT_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk or posedge rst_clk) begin
        if (rst_clk) begin
            r_perf_cnt <= '0;
        end else begin
            r_perf_cnt <= r_perf_cnt + 32'(w_ret_cnt);
        end
    end

    assign perf_retire_cnt = r_perf_cnt;
`else
    assign perf_retire_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rtu_rob_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtu_rob_multi
// Description : Directed self-checking bench for rtu_rob_multi (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtu_rob_multi;

    localparam int IW = 4;

    logic         clk;
    logic         rst_clk;
    logic         create_vld;
    logic         create_rdy;
    logic [3:0]   create_iid;
    logic [63:0]  create_pc;
    logic         create_pdst_vld;
    logic [5:0]   create_pdst;
    logic [4:0]   cpl_vld;
    logic [19:0]  cpl_iid;
    logic         pcjump_vld;
    logic [3:0]   pcjump_iid;
    logic [1:0]   retire_vld;
    logic [7:0]   retire_iid;
    logic [127:0] retire_pc;
    logic [1:0]   retire_pdst_vld;
    logic [11:0]  retire_pdst;
    logic         rtu_global_flush;
    logic [4:0]   entry_cnt;
    logic [31:0]  perf_retire_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int ret_total = 0;
    int ret_since_rst = 0;
    logic [3:0] exp_iid = '0;

    rtu_rob_multi dut (
        .clk              (clk),
        .rst_clk          (rst_clk),
        .create_vld       (create_vld),
        .create_rdy       (create_rdy),
        .create_iid       (create_iid),
        .create_pc        (create_pc),
        .create_pdst_vld  (create_pdst_vld),
        .create_pdst      (create_pdst),
        .cpl_vld          (cpl_vld),
        .cpl_iid          (cpl_iid),
        .pcjump_vld       (pcjump_vld),
        .pcjump_iid       (pcjump_iid),
        .retire_vld       (retire_vld),
        .retire_iid       (retire_iid),
        .retire_pc        (retire_pc),
        .retire_pdst_vld  (retire_pdst_vld),
        .retire_pdst      (retire_pdst),
        .rtu_global_flush (rtu_global_flush),
        .entry_cnt        (entry_cnt),
        .perf_retire_cnt  (perf_retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        create_vld = 1'b0;
        cpl_vld    = '0;
        cpl_iid    = '0;
        pcjump_vld = 1'b0;
        pcjump_iid = '0;
    endtask

    task automatic set_cpl(input int p, input int iid);
        cpl_vld[p]          = 1'b1;
        cpl_iid[p*IW +: IW] = 4'(iid);
    endtask

    task automatic set_create(input int i);
        create_vld      = 1'b1;
        create_pc       = 64'h1000 + 64'(4 * i);
        create_pdst_vld = 1'((i % 2));
        create_pdst     = 6'(i);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (entry_cnt != 0 && n < 50) begin
            tick();
            n++;
        end
        check(tag, 128'(entry_cnt), 128'd0);
    endtask

    // Retire scoreboard: iids must leave strictly in order, never during flush.
    always @(negedge clk) begin
        if (rst_clk) begin
            exp_iid       = '0;
            ret_since_rst = 0;
        end else if (rtu_global_flush) begin
            check("flush_noret", 128'(retire_vld), 128'd0);
            exp_iid = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (retire_vld[k]) begin
                    check("ret_order", 128'(retire_iid[k*IW +: IW]), 128'(exp_iid));
                    exp_iid = exp_iid + 4'd1;
                    ret_total++;
                    ret_since_rst++;
                end
            end
        end
    end

    initial begin
        rst_clk = 1'b1;
        create_pc = '0;
        create_pdst_vld = 1'b0;
        create_pdst = '0;
        clr_in();
        #2;
        check("rst_retire_vld", 128'(retire_vld), 128'd0);
        check("rst_entry_cnt",  128'(entry_cnt), 128'd0);
        check("rst_create_rdy", 128'(create_rdy), 128'd1);
        check("rst_create_iid", 128'(create_iid), 128'd0);
        check("rst_flush",      128'(rtu_global_flush), 128'd0);
        check("rst_perf",       128'(perf_retire_cnt), 128'd0);
        tick();
        tick();
        rst_clk = 1'b0;

        // Fill all 16 entries with no completions.
        for (int i = 0; i < 16; i++) begin
            set_create(i);
            check("fill_iid", 128'(create_iid), 128'(i));
            tick();
        end
        clr_in();
        check("full_rdy", 128'(create_rdy), 128'd0);
        check("full_cnt", 128'(entry_cnt), 128'd16);

        // Out-of-order completion: 1 then 0 gives a two-wide retire.
        set_cpl(0, 1);
        tick();
        clr_in();
        check("no_ret_iid1", 128'(retire_vld), 128'd0);
        set_cpl(3, 0);
        tick();
        clr_in();
        check("ret2_vld",      128'(retire_vld), 128'b11);
        check("ret2_iid",      128'(retire_iid), 128'h10);
        check("ret2_pc0",      128'(retire_pc[63:0]), 128'h1000);
        check("ret2_pc1",      128'(retire_pc[127:64]), 128'h1004);
        check("ret2_pdst_vld", 128'(retire_pdst_vld), 128'b10);
        check("ret2_pdst",     128'(retire_pdst), 128'h040);
        tick();
        check("cnt_after_ret2", 128'(entry_cnt), 128'd14);
        check("ret_idle",       128'(retire_vld), 128'd0);

        // Retire iid2 alone, then jump on iid3 with iid4 also complete.
        set_cpl(1, 2);
        tick();
        clr_in();
        check("ret_iid2_vld", 128'(retire_vld), 128'b01);
        check("ret_iid2",     128'(retire_iid[3:0]), 128'd2);
        set_cpl(0, 3);
        set_cpl(2, 4);
        pcjump_vld = 1'b1;
        pcjump_iid = 4'd3;
        tick();
        clr_in();
        check("jmp_ret_vld",  128'(retire_vld), 128'b01);
        check("jmp_ret_iid",  128'(retire_iid[3:0]), 128'd3);
        check("jmp_no_flush", 128'(rtu_global_flush), 128'd0);
        tick();
        check("flush_on",  128'(rtu_global_flush), 128'd1);
        check("flush_rdy", 128'(create_rdy), 128'd0);
        check("flush_ret", 128'(retire_vld), 128'd0);
        set_create(0);
        set_cpl(0, 5);
        pcjump_vld = 1'b1;
        pcjump_iid = 4'd6;
        tick();
        clr_in();
        check("flush_off",      128'(rtu_global_flush), 128'd0);
        check("post_flush_cnt", 128'(entry_cnt), 128'd0);
        check("post_flush_iid", 128'(create_iid), 128'd0);
        tick();
        check("flush_create_ignored", 128'(entry_cnt), 128'd0);

        // Streaming across the wrap: create i while completing i-1.
        for (int i = 0; i < 20; i++) begin
            set_create(i);
            if (i > 0) set_cpl(0, (i - 1) % 16);
            check("wrap_iid", 128'(create_iid), 128'(i % 16));
            tick();
            clr_in();
        end
        check("wrap_cnt", 128'(entry_cnt), 128'd2);
        set_cpl(0, 3);
        tick();
        clr_in();
        wait_drain("wrap_drain");
        check("wrap_total", 128'(ret_total), 128'd24);
        check("wrap_iid_next", 128'(create_iid), 128'd4);

        // Asynchronous reset mid-stream with seven entries in flight.
        for (int i = 0; i < 7; i++) begin
            set_create(i);
            tick();
        end
        clr_in();
        check("pre_rst_cnt", 128'(entry_cnt), 128'd7);
        set_cpl(0, 4);
        set_cpl(1, 5);
        tick();
        clr_in();
        check("pre_rst_ret", 128'(retire_vld), 128'b11);
        #2;
        rst_clk = 1'b1;
        #1;
        check("arst_ret_vld", 128'(retire_vld), 128'd0);
        check("arst_cnt",     128'(entry_cnt), 128'd0);
        check("arst_rdy",     128'(create_rdy), 128'd1);
        check("arst_iid",     128'(create_iid), 128'd0);
        check("arst_perf",    128'(perf_retire_cnt), 128'd0);
        tick();
        rst_clk = 1'b0;

        // Ten retires for the performance counter.
        for (int i = 0; i < 10; i++) begin
            set_create(i);
            tick();
        end
        clr_in();
        for (int p = 0; p < 5; p++) set_cpl(p, p);
        tick();
        clr_in();
        for (int p = 0; p < 5; p++) set_cpl(p, p + 5);
        tick();
        clr_in();
        wait_drain("perf_drain");
        tick();
        check("perf_ret_seen", 128'(ret_since_rst), 128'd10);
`ifdef RTU_ROB_PERF_CNT_EN
        check("perf_cnt", 128'(perf_retire_cnt), 128'd10);
`else
        check("perf_cnt", 128'(perf_retire_cnt), 128'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
